// File: rtl/fir_feeder_pkg.sv
// Shared types and default parameter values for the FIR sample feeder.
package fir_feeder_pkg;

    localparam int DEF_WIDTH        = 16;
    localparam int DEF_OUT_WIDTH    = 38;
    localparam int DEF_DEPTH        = 64;
    localparam int DEF_SETUP_CYCLES = 5;
    localparam int DEF_TIMEOUT      = 255;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } feeder_state_t;

endpackage

// File: rtl/fir_sample_ram.sv
// Sample store: synchronous write port, registered read port.
// The read register is cleared by reset because it directly drives the
// sample presented to the filter; the array itself keeps its contents.
module fir_sample_ram
    import fir_feeder_pkg::*;
#(
    parameter int  WIDTH  = DEF_WIDTH,
    parameter int  DEPTH  = DEF_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: store a sample when the write strobe is high.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: the output only changes when a read is requested, so it
    // holds the current sample steady for as long as the feeder needs it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fir_sample_feeder.sv
// Feeds stored samples one at a time to an external FIR filter, waits for
// each result (with a timeout) and reports the captured results.
module fir_sample_feeder
    import fir_feeder_pkg::*;
#(
    parameter int  WIDTH        = DEF_WIDTH,
    parameter int  OUT_WIDTH    = DEF_OUT_WIDTH,
    parameter int  DEPTH        = DEF_DEPTH,
    parameter int  SETUP_CYCLES = DEF_SETUP_CYCLES,
    parameter int  TIMEOUT      = DEF_TIMEOUT,
    localparam int ADDR_W       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_we,
    input  logic [ADDR_W-1:0]    load_addr,
    input  logic [WIDTH-1:0]     load_data,
    input  logic [ADDR_W:0]      num_samples,
    input  logic                 start,
    output logic [WIDTH-1:0]     FIR_input,
    output logic                 input_valid,
    input  logic                 output_valid,
    input  logic [OUT_WIDTH-1:0] FIR_output,
    output logic [OUT_WIDTH-1:0] result_data,
    output logic [ADDR_W-1:0]    result_index,
    output logic                 result_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err
);

    localparam int SC_W = $clog2(SETUP_CYCLES + 1);
    localparam int WC_W = $clog2(TIMEOUT + 1);

    localparam logic [SC_W-1:0] SETUP_LAST = SC_W'(SETUP_CYCLES - 1);
    localparam logic [WC_W-1:0] WAIT_LAST  = WC_W'(TIMEOUT - 1);

    feeder_state_t     state;
    feeder_state_t     state_next;

    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] index;
    logic [SC_W-1:0]   setup_cnt;
    logic [WC_W-1:0]   wait_cnt;
    logic              ov_prev;

    logic              start_run;
    logic              setup_last;
    logic              wait_last;
    logic              edge_seen;
    logic              last_sample;

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              ram_we;

    assign busy        = (state != S_IDLE);
    assign input_valid = (state == S_PULSE);
    assign start_run   = (state == S_IDLE) && start && (num_samples != '0);
    assign setup_last  = (setup_cnt == SETUP_LAST);
    assign wait_last   = (wait_cnt == WAIT_LAST);
    assign edge_seen   = (state == S_WAIT) && output_valid && !ov_prev;
    assign last_sample = ({1'b0, index} == (count - (ADDR_W + 1)'(1)));

    // Host writes are only accepted while no run is in progress.
    assign ram_we = load_we && !busy;

    fir_sample_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (load_addr),
        .wdata (load_data),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (FIR_input)
    );

    // Next-state decode; the RAM read is issued on the same edge that
    // enters SETUP so the new sample appears together with the state change.
    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        rd_addr    = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (num_samples == '0) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_SETUP;
                        rd_en      = 1'b1;
                        rd_addr    = '0;
                    end
                end
            end
            S_SETUP: begin
                if (setup_last) begin
                    state_next = S_PULSE;
                end
            end
            S_PULSE: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (edge_seen) begin
                    if (last_sample) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_SETUP;
                        rd_en      = 1'b1;
                        rd_addr    = index + ADDR_W'(1);
                    end
                end else if (wait_last) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Phase counters and output_valid history; counters restart on every
    // phase entry, and the history register makes a level already high on
    // WAIT entry look like "no edge".
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            setup_cnt <= '0;
            wait_cnt  <= '0;
            ov_prev   <= 1'b0;
        end else begin
            ov_prev <= output_valid;
            if (state == S_SETUP && state_next == S_SETUP) begin
                setup_cnt <= setup_cnt + SC_W'(1);
            end else begin
                setup_cnt <= '0;
            end
            if (state == S_WAIT && state_next == S_WAIT) begin
                wait_cnt <= wait_cnt + WC_W'(1);
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    // Run bookkeeping: latch the sample count at start and step the index
    // after each capture, never past the last sample of the run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            index <= '0;
        end else if (start_run) begin
            count <= num_samples;
            index <= '0;
        end else if (edge_seen && !last_sample) begin
            index <= index + ADDR_W'(1);
        end
    end

    // Result capture, sticky timeout flag and the end-of-run pulse; an edge
    // arriving in the final WAIT cycle takes priority over the timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_data  <= '0;
            result_index <= '0;
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
            done         <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            done         <= (state == S_DONE);
            if (start_run) begin
                timeout_err <= 1'b0;
            end
            if (edge_seen) begin
                result_data  <= FIR_output;
                result_index <= index;
                result_valid <= 1'b1;
            end else if (state == S_WAIT && wait_last) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Directed self-checking bench for the FIR sample feeder.
module tb_fir_sample_feeder;

    localparam int FILTER_LAT = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_we;
    logic [5:0]  load_addr;
    logic [15:0] load_data;
    logic [6:0]  num_samples;
    logic        start;
    logic [15:0] FIR_input;
    logic        input_valid;
    logic        output_valid;
    logic [37:0] FIR_output;
    logic [37:0] result_data;
    logic [5:0]  result_index;
    logic        result_valid;
    logic        busy;
    logic        done;
    logic        timeout_err;

    // filter model and manual output_valid override
    logic        model_en = 1'b0;
    logic        model_ov = 1'b0;
    int          model_cnt = 0;
    logic [37:0] model_data = '0;
    logic        hold_ov;
    logic [37:0] manual_data;

    assign output_valid = model_ov | hold_ov;
    assign FIR_output   = hold_ov ? manual_data : model_data;

    // monitor state
    int          cyc = 0;
    int          last_fi_change = 0;
    logic [15:0] fi_prev = '0;
    int          iv_count = 0;
    int          done_count = 0;
    int          iv_gap[$];
    logic [15:0] iv_data[$];
    logic [37:0] rv_data[$];
    logic [5:0]  rv_idx[$];

    int          check_count = 0;
    int          pass_count = 0;

    fir_sample_feeder dut (
        .clk          (clk),
        .rst          (rst),
        .load_we      (load_we),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .num_samples  (num_samples),
        .start        (start),
        .FIR_input    (FIR_input),
        .input_valid  (input_valid),
        .output_valid (output_valid),
        .FIR_output   (FIR_output),
        .result_data  (result_data),
        .result_index (result_index),
        .result_valid (result_valid),
        .busy         (busy),
        .done         (done),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    // filter model: answers FILTER_LAT cycles after each input_valid with 3*sample
    always @(negedge clk) begin
        if (model_en && input_valid) begin
            model_cnt  <= FILTER_LAT;
            model_data <= 38'(FIR_input) * 38'd3;
            model_ov   <= 1'b0;
        end else if (model_cnt == 1) begin
            model_cnt <= 0;
            model_ov  <= 1'b1;
        end else begin
            if (model_cnt > 0) model_cnt <= model_cnt - 1;
            model_ov <= 1'b0;
        end
    end

    // monitor: records strobes and the distance from sample change to input_valid
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (FIR_input !== fi_prev) begin
            last_fi_change <= cyc;
            fi_prev        <= FIR_input;
        end
        if (input_valid) begin
            iv_count <= iv_count + 1;
            iv_gap.push_back(cyc - last_fi_change);
            iv_data.push_back(FIR_input);
        end
        if (done) done_count <= done_count + 1;
        if (result_valid) begin
            rv_data.push_back(result_data);
            rv_idx.push_back(result_index);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_count++;
        if (obs !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            pass_count++;
        end
    endtask

    task automatic loadSample(input int addr, input logic [15:0] data);
        load_we   = 1'b1;
        load_addr = 6'(addr);
        load_data = data;
        tick();
        load_we   = 1'b0;
    endtask

    task automatic applyStimulus(input int n);
        num_samples = 7'(n);
        start       = 1'b1;
        tick();
        start       = 1'b0;
        num_samples = '0;
    endtask

    task automatic waitDone(input int budget, input string tag);
        int base;
        int i;
        base = done_count;
        i = 0;
        while (done_count == base && i < budget) begin
            tick();
            i++;
        end
        checkOutput({tag, "_done_seen"}, 64'(done_count > base), 64'd1);
    endtask

    task automatic waitIv(input int target, input int budget, input string tag);
        int i;
        i = 0;
        while (iv_count < target && i < budget) begin
            tick();
            i++;
        end
        checkOutput({tag, "_iv_seen"}, 64'(iv_count >= target), 64'd1);
    endtask

    // safety net in case a bounded wait is somehow bypassed
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0] exp_smp [3];
        logic [37:0] exp_res [3];
        int b_iv, b_gap, b_rv, b_done;

        exp_smp[0] = 16'h0001; exp_smp[1] = 16'h7FFF; exp_smp[2] = 16'h8000;
        exp_res[0] = 38'h3;    exp_res[1] = 38'h17FFD; exp_res[2] = 38'h18000;

        load_we = 0; load_addr = '0; load_data = '0; num_samples = '0; start = 0;
        hold_ov = 0; manual_data = '0;

        #2 rst = 1'b0;
        repeat (3) tick();
        $display("[TB] reset state");
        checkOutput("rst_fir_input", 64'(FIR_input), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_strobes", 64'({input_valid, result_valid, done, timeout_err}), 64'd0);
        checkOutput("rst_result", 64'({result_data, result_index}), 64'd0);
        rst = 1'b1;
        tick();

        loadSample(0, 16'h0001);
        loadSample(1, 16'h7FFF);
        loadSample(2, 16'h8000);
        loadSample(3, 16'h1234);

        // three-sample run with a responsive filter
        $display("[TB] three-sample run");
        model_en = 1'b1;
        b_iv = iv_count; b_gap = iv_gap.size(); b_rv = rv_data.size(); b_done = done_count;
        applyStimulus(3);
        checkOutput("run3_busy", 64'(busy), 64'd1);
        checkOutput("run3_first_sample", 64'(FIR_input), 64'h0001);
        waitDone(600, "run3");
        repeat (3) tick();
        checkOutput("run3_iv_count", 64'(iv_count - b_iv), 64'd3);
        checkOutput("run3_rv_count", 64'(rv_data.size() - b_rv), 64'd3);
        checkOutput("run3_done_count", 64'(done_count - b_done), 64'd1);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("run3_gap%0d", i), 64'(iv_gap[b_gap + i]), 64'd5);
            checkOutput($sformatf("run3_sample%0d", i), 64'(iv_data[b_gap + i]), 64'(exp_smp[i]));
            checkOutput($sformatf("run3_index%0d", i), 64'(rv_idx[b_rv + i]), 64'(i));
            checkOutput($sformatf("run3_data%0d", i), 64'(rv_data[b_rv + i]), 64'(exp_res[i]));
        end
        checkOutput("run3_timeout_err", 64'(timeout_err), 64'd0);
        checkOutput("run3_busy_end", 64'(busy), 64'd0);

        // zero-length run: straight to done
        $display("[TB] zero-length run");
        b_iv = iv_count;
        applyStimulus(0);
        checkOutput("zero_done_early", 64'(done), 64'd0);
        checkOutput("zero_busy", 64'(busy), 64'd1);
        tick();
        checkOutput("zero_done_pulse", 64'(done), 64'd1);
        checkOutput("zero_busy_end", 64'(busy), 64'd0);
        tick();
        checkOutput("zero_done_single", 64'(done), 64'd0);
        checkOutput("zero_no_iv", 64'(iv_count - b_iv), 64'd0);

        // silent filter: timeout on the first sample
        $display("[TB] timeout run");
        model_en = 1'b0;
        b_iv = iv_count; b_rv = rv_data.size(); b_done = done_count;
        applyStimulus(2);
        repeat (260) tick();
        checkOutput("tmo_not_yet", 64'(timeout_err), 64'd0);
        checkOutput("tmo_busy", 64'(busy), 64'd1);
        tick();
        checkOutput("tmo_flag", 64'(timeout_err), 64'd1);
        waitDone(10, "tmo");
        repeat (3) tick();
        checkOutput("tmo_iv_count", 64'(iv_count - b_iv), 64'd1);
        checkOutput("tmo_rv_count", 64'(rv_data.size() - b_rv), 64'd0);
        checkOutput("tmo_done_count", 64'(done_count - b_done), 64'd1);
        checkOutput("tmo_sticky", 64'(timeout_err), 64'd1);

        // output_valid already high: only a fresh rising edge captures
        $display("[TB] held output_valid");
        hold_ov = 1'b1;
        manual_data = 38'h2_ABCD_1234;
        b_rv = rv_data.size();
        applyStimulus(1);
        checkOutput("hold_tmo_cleared", 64'(timeout_err), 64'd0);
        repeat (20) tick();
        checkOutput("hold_no_capture", 64'(rv_data.size() - b_rv), 64'd0);
        checkOutput("hold_busy", 64'(busy), 64'd1);
        hold_ov = 1'b0;
        repeat (2) tick();
        hold_ov = 1'b1;
        tick();
        checkOutput("hold_rv", 64'(result_valid), 64'd1);
        checkOutput("hold_data", 64'(result_data), 64'h2_ABCD_1234);
        checkOutput("hold_index", 64'(result_index), 64'd0);
        waitDone(20, "hold");
        hold_ov = 1'b0;
        repeat (3) tick();

        // reset while waiting on sample 1 of 4
        $display("[TB] reset mid-run");
        model_en = 1'b1;
        b_iv = iv_count;
        applyStimulus(4);
        waitIv(b_iv + 2, 200, "midrst");
        repeat (5) tick();
        checkOutput("midrst_busy_before", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        checkOutput("midrst_fir_busy", 64'({FIR_input, busy}), 64'd0);
        checkOutput("midrst_strobes", 64'({input_valid, result_valid, done, timeout_err}), 64'd0);
        checkOutput("midrst_result", 64'({result_data, result_index}), 64'd0);
        repeat (3) tick();
        rst = 1'b1;
        b_iv = iv_count; b_rv = rv_data.size(); b_done = done_count;
        repeat (50) tick();
        checkOutput("midrst_quiet", 64'({iv_count - b_iv, done_count - b_done}), 64'd0);
        checkOutput("midrst_no_rv", 64'(rv_data.size() - b_rv), 64'd0);
        applyStimulus(2);
        checkOutput("midrst_restart_sample", 64'(FIR_input), 64'h0001);
        waitDone(400, "midrst_rerun");
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("midrst_index%0d", i), 64'(rv_idx[b_rv + i]), 64'(i));
            checkOutput($sformatf("midrst_data%0d", i), 64'(rv_data[b_rv + i]), 64'(exp_res[i]));
        end

        // start and host writes while busy are ignored
        $display("[TB] activity during run");
        b_iv = iv_count; b_gap = iv_gap.size(); b_done = done_count;
        applyStimulus(3);
        repeat (2) tick();
        start = 1'b1; num_samples = 7'd1;
        load_we = 1'b1; load_addr = 6'd1; load_data = 16'hDEAD;
        tick();
        start = 1'b0; num_samples = '0; load_we = 1'b0;
        waitIv(b_iv + 1, 50, "busy");
        repeat (10) tick();
        start = 1'b1; num_samples = 7'd5;
        load_we = 1'b1; load_addr = 6'd2; load_data = 16'hBEEF;
        tick();
        start = 1'b0; num_samples = '0; load_we = 1'b0;
        waitDone(400, "busy");
        repeat (10) tick();
        checkOutput("busy_iv_count", 64'(iv_count - b_iv), 64'd3);
        checkOutput("busy_done_count", 64'(done_count - b_done), 64'd1);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("busy_sample%0d", i), 64'(iv_data[b_gap + i]), 64'(exp_smp[i]));
        end
        b_gap = iv_gap.size();
        applyStimulus(3);
        waitDone(400, "readback");
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("readback%0d", i), 64'(iv_data[b_gap + i]), 64'(exp_smp[i]));
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/fir_sample_feeder.md
FIR_SAMPLE_FEEDER -- requirements
Module: fir_sample_feeder

Interface
REQ-001 Parameter WIDTH, default 16, sample width presented to the filter.
REQ-002 Parameter OUT_WIDTH, default 38, width of the filter result.
REQ-003 Parameter DEPTH, default 64, sample memory entries; ADDR_W = clog2(DEPTH).
REQ-004 Parameter SETUP_CYCLES, default 5, cycles FIR_input is stable before input_valid.
REQ-005 Parameter TIMEOUT, default 255, max WAIT cycles for output_valid.
REQ-006 Port clk  in  1  single clock; all state on rising edge.
REQ-007 Port rst  in  1  reset, asynchronous, active-low.
REQ-008 Port load_we / load_addr / load_data  in  1/ADDR_W/WIDTH  sample memory write.
REQ-009 Port num_samples  in  ADDR_W+1  samples to send, sampled on start.
REQ-010 Port start  in  1  one-cycle request to begin a run.
REQ-011 Port FIR_input  out  WIDTH  sample to filter.
REQ-012 Port input_valid  out  1  one-cycle strobe to filter.
REQ-013 Port output_valid  in  1  filter result strobe (level, edge-detected).
REQ-014 Port FIR_output  in  OUT_WIDTH  filter result.
REQ-015 Ports result_data / result_index / result_valid  out  OUT_WIDTH/ADDR_W/1  captured result, its sample index, one-cycle strobe.
REQ-016 Ports busy / done / timeout_err  out  1 each  run active, end-of-run pulse, sticky timeout flag.

Function
REQ-017 FSM states IDLE, SETUP, PULSE, WAIT, DONE SHALL exist; IDLE on reset.
REQ-018 IDLE: start=1 with num_samples>0 SHALL latch count, set index=0, clear timeout_err, go to SETUP; num_samples=0 SHALL go directly to DONE.
REQ-019 Entry to SETUP SHALL load FIR_input from memory[index] within one cycle; FIR_input SHALL stay constant through SETUP, PULSE, WAIT.
REQ-020 SETUP SHALL last exactly SETUP_CYCLES cycles, then PULSE.
REQ-021 PULSE SHALL assert input_valid for exactly one cycle, then WAIT.
REQ-022 WAIT: rising edge of output_valid (0 in previous cycle, 1 now) SHALL capture FIR_output into result_data, index into result_index, pulse result_valid next cycle.
REQ-023 After capture, index SHALL increment; index==count-1 SHALL go to DONE, else SETUP.
REQ-024 WAIT reaching TIMEOUT cycles without edge SHALL set timeout_err and go to DONE; no result_valid for that sample.
REQ-025 output_valid high on WAIT entry SHALL NOT count as an edge; edges outside WAIT SHALL be ignored.
REQ-026 DONE SHALL pulse done for one cycle, then IDLE.
REQ-027 busy SHALL be 1 in SETUP, PULSE, WAIT, DONE; 0 in IDLE.
REQ-028 start while busy SHALL be ignored; load_we while busy SHALL be ignored.
REQ-029 Edge on the same cycle as timeout expiry SHALL win (capture, no timeout).
REQ-030 Index arithmetic SHALL be unsigned, no wrap beyond count-1.

Reset
REQ-031 rst low SHALL force immediately: state IDLE, FIR_input=0, input_valid=0, result_data=0, result_index=0, result_valid=0, busy=0, done=0, timeout_err=0, counters 0, edge register 0.
REQ-032 Reset mid-run SHALL abort with no further strobes; memory contents need not be cleared.

Structure
REQ-033 Package fir_feeder_pkg SHALL hold the state enum and default parameter constants.
REQ-034 Sub-module fir_sample_ram (sync write, registered read, DEPTH x WIDTH) SHALL hold samples.

Verification
REQ-035 Load 3 samples 0x0001,0x7FFF,0x8000, num_samples=3, model filter answers 40 cycles after each input_valid -> three input_valid pulses, each 5 cycles after FIR_input change, result_index 0,1,2, done once.
REQ-036 num_samples=0, start -> done pulse 2 cycles later, no input_valid.
REQ-037 Filter never answers, num_samples=2 -> timeout_err=1 at WAIT cycle 255, done pulse, one input_valid only.
REQ-038 output_valid held high before first PULSE -> no capture until it falls and rises again.
REQ-039 rst low during WAIT of sample 1 of 4 -> all outputs 0 immediately; next start restarts at index 0.
REQ-040 start pulses and load_we writes during a run -> ignored; memory readback and run count unchanged.
